param_serializer: RTL

- Parametrised single-lane parallel-to-serial converter that runs entirely in the clk_32f domain; no clk_4f input.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB- or LSB-first.
- Inserts IDLE_WORD (comma) whenever no word is offered at a word boundary.
- After every reset, transmits a fixed number of idle words before it will accept data, so the downstream deserialiser can align.
- Sits between the byte-level transmit logic and the serial link.

---
 rtl/param_serializer_if.sv | 24 ++
 rtl/param_serializer.sv | 83 ++++++++
 2 files changed

// File: rtl/param_serializer_if.sv
// Parallel-word handshake and serial-side status of param_serializer.
// The source drives the master side; the serializer owns the slave side.
interface param_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             data_out;
    logic             word_start;
    logic             sending_data;
    logic [WIDTH-1:0] data2send;
    logic             sync_done;

    modport master (
        output data_in, valid_in,
        input  ready_out, data_out, word_start, sending_data, data2send, sync_done
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, data_out, word_start, sending_data, data2send, sync_done
    );
endinterface

// File: rtl/param_serializer.sv
// Single-lane parallel-to-serial converter in the clk_32f domain.
// It sends SYNC_WORDS comma words after reset, then data or commas word by word.
module param_serializer #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD  = 'hBC,
    parameter int               MSB_FIRST  = 1,
    parameter int               SYNC_WORDS = 4
) (
    input logic              clk_32f,
    input logic              reset,
    param_serializer_if.slave bus
);
    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SYNC_W = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);

    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic              data_out_q, data_out_d;
    logic              word_start_q, word_start_d;
    logic              sending_data_q, sending_data_d;

    logic              boundary;
    logic              sync_done;
    logic              ready;
    logic [CNT_W-1:0]  bit_idx;

    always_comb begin
        boundary  = (cnt_q == CNT_LAST);
        sync_done = (sync_cnt_q == SYNC_LAST);
        ready     = sync_done && boundary;
        bit_idx   = (MSB_FIRST != 0) ? (CNT_LAST - cnt_q) : cnt_q;

        data_out_d     = sh_q[bit_idx];
        word_start_d   = (cnt_q == '0);
        cnt_d          = boundary ? '0 : cnt_q + 1'b1;
        sh_d           = sh_q;
        sending_data_d = sending_data_q;
        sync_cnt_d     = sync_cnt_q;

        if (boundary) begin
            if (bus.valid_in && ready) begin
                sh_d           = bus.data_in;
                sending_data_d = 1'b1;
            end else begin
                sh_d           = IDLE_WORD;
                sending_data_d = 1'b0;
            end
            // Saturates at SYNC_LAST, so sync_done stays high until reset.
            if (!sync_done) begin
                sync_cnt_d = sync_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            sh_q           <= IDLE_WORD;
            cnt_q          <= '0;
            sync_cnt_q     <= '0;
            data_out_q     <= 1'b0;
            word_start_q   <= 1'b0;
            sending_data_q <= 1'b0;
        end else begin
            sh_q           <= sh_d;
            cnt_q          <= cnt_d;
            sync_cnt_q     <= sync_cnt_d;
            data_out_q     <= data_out_d;
            word_start_q   <= word_start_d;
            sending_data_q <= sending_data_d;
        end
    end

    // The word register is indexed in place rather than shifted, so it doubles as data2send.
    assign bus.data2send    = sh_q;
    assign bus.data_out     = data_out_q;
    assign bus.word_start   = word_start_q;
    assign bus.sending_data = sending_data_q;
    assign bus.sync_done    = sync_done;
    assign bus.ready_out    = ready;
endmodule
